// File: rtl/bip_control.sv
// BIP processor control unit: opcode decode into datapath strobes, PC advance,
// run/step/halt sequencing and a saturating retired-instruction counter.
module bip_control #(
    parameter int unsigned PC_LENGTH     = 11,
    parameter int unsigned OPCODE_LENGTH = 5,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     step,
    input  logic [OPCODE_LENGTH-1:0] opcode,
    input  logic [PC_LENGTH-1:0]     program_count,
    output logic [PC_LENGTH-1:0]     new_program_count,
    output logic                     enable,
    output logic [1:0]               sel_a,
    output logic                     sel_b,
    output logic                     op,
    output logic                     wr_acc,
    output logic                     wr_ram,
    output logic                     rd_ram,
    output logic                     halted,
    output logic [COUNT_WIDTH-1:0]   instr_count
);

    typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

    localparam logic [OPCODE_LENGTH-1:0] OpHlt  = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OpSto  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OpLd   = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OpLdi  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OpAdd  = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OpAddi = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OpSub  = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OpSubi = OPCODE_LENGTH'(7);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   active;
    logic                   is_hlt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign active = (state_q == StRun) || (state_q == StStep);
    assign is_hlt = (opcode == OpHlt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end else if (step) begin
                    state_d = StStep;
                end
            end
            StRun:    state_d = is_hlt ? StHalted : StRun;
            StStep:   state_d = is_hlt ? StHalted : StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    // HLT never retires, so the count matches the number of PC advances.
    always_comb begin
        count_d = count_q;
        if (active && !is_hlt && (count_q != '1)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        enable = 1'b0;
        sel_a  = 2'b00;
        sel_b  = 1'b0;
        op     = 1'b0;
        wr_acc = 1'b0;
        wr_ram = 1'b0;
        rd_ram = 1'b0;
        if (active) begin
            case (opcode)
                OpHlt: ;
                OpSto: begin
                    wr_ram = 1'b1;
                    enable = 1'b1;
                end
                OpLd: begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                    enable = 1'b1;
                end
                OpLdi: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b01;
                    enable = 1'b1;
                end
                OpAdd, OpSub: begin
                    rd_ram = 1'b1;
                    wr_acc = 1'b1;
                    sel_a  = 2'b10;
                    op     = (opcode == OpSub);
                    enable = 1'b1;
                end
                OpAddi, OpSubi: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b10;
                    sel_b  = 1'b1;
                    op     = (opcode == OpSubi);
                    enable = 1'b1;
                end
                default: enable = 1'b1;
            endcase
        end
    end

    assign new_program_count = program_count + PC_LENGTH'(1);
    assign halted            = (state_q == StHalted);
    assign instr_count       = count_q;

endmodule

// File: doc/bip_control.md
# bip_control

Control unit of the BIP processor. It decodes the 5-bit opcode of the current instruction into datapath strobes and drives the program counter's `enable` and `new_program_count` inputs. A small run/step/halt state machine gates execution and halts the core on `HLT`. A saturating counter tracks retired instructions for the debug unit.

## Interface
- `PC_LENGTH`, 11, program-counter / instruction-memory address width
- `OPCODE_LENGTH`, 5, opcode field width
- `COUNT_WIDTH`, 16, retired-instruction counter width

Ports:
- `clk`  in  1  system clock; all state in this block updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  level; in IDLE, begin free-running execution
- `step`  in  1  level; in IDLE, execute exactly one instruction
- `opcode`  in  OPCODE_LENGTH  opcode of the instruction addressed by the PC
- `program_count`  in  PC_LENGTH  current PC value
- `new_program_count`  out  PC_LENGTH  next PC (`program_count + 1`)
- `enable`  out  1  PC write enable (wr_pc)
- `sel_a`  out  2  accumulator source: 00 memory, 01 immediate, 10 ALU
- `sel_b`  out  1  ALU operand B: 0 memory, 1 immediate
- `op`  out  1  ALU operation: 0 add, 1 subtract
- `wr_acc`  out  1  accumulator write
- `wr_ram`  out  1  data-memory write
- `rd_ram`  out  1  data-memory read
- `halted`  out  1  high in HALTED
- `instr_count`  out  COUNT_WIDTH  retired instructions

## Operation
- **States:** IDLE, RUN, STEP, HALTED. Reset value is IDLE.
- **IDLE**
  - `start`=1 → RUN.
  - Else `step`=1 → STEP.
  - `start` wins if both are high.
- **RUN**
  - `opcode`=HLT → HALTED.
  - Otherwise stay in RUN.
  - `start`/`step` are ignored.
- **STEP**
  - `opcode`=HLT → HALTED.
  - Otherwise → IDLE.
- **HALTED:** held until `reset`. `start`/`step` are ignored.
- **Strobe gating:** decode outputs are combinational from `opcode` and the current state. They are active only in RUN or STEP. In IDLE and HALTED, all strobes, `enable`, `sel_a`, `sel_b` and `op` are 0.
- **Decode (active states).** Unlisted fields are 0.
  - HLT 00000: all 0, `enable`=0.
  - STO 00001: `wr_ram`=1, `enable`=1.
  - LD 00010: `rd_ram`=1, `wr_acc`=1, `sel_a`=00, `enable`=1.
  - LDI 00011: `wr_acc`=1, `sel_a`=01, `enable`=1.
  - ADD 00100: `rd_ram`=1, `wr_acc`=1, `sel_a`=10, `sel_b`=0, `op`=0, `enable`=1.
  - ADDI 00101: `wr_acc`=1, `sel_a`=10, `sel_b`=1, `op`=0, `enable`=1.
  - SUB 00110: `rd_ram`=1, `wr_acc`=1, `sel_a`=10, `sel_b`=0, `op`=1, `enable`=1.
  - SUBI 00111: `wr_acc`=1, `sel_a`=10, `sel_b`=1, `op`=1, `enable`=1.
  - 01000–11111: NOP; only `enable`=1.
- **Next PC:** `new_program_count` = (`program_count` + 1) mod 2^PC_LENGTH. It is always driven, independent of state. 2047 wraps to 0.
- **`instr_count`:** increments on each rising edge where the state is RUN or STEP and `opcode` ≠ HLT. It saturates at 2^COUNT_WIDTH−1 and is never cleared except by reset.
- **`halted`:** registered state decode. It is 1 exactly while the state is HALTED.

## Timing
- **Reset:** `reset`=1 at a rising edge forces IDLE and `instr_count`=0, regardless of the current state (including mid-RUN). Combinational outputs then follow IDLE (all 0). `halted`=0.
- **PC timing:** the PC samples `enable` and `new_program_count` on the falling edge. Strobes change only after rising edges or `opcode`/`program_count` changes, giving a half-cycle setup.
- **Per-instruction cadence:** one instruction retires per clock in RUN.
- **Start latency:** `start` sampled at rising edge N → strobes for the instruction at the current PC are valid from edge N. The first PC advance occurs at the falling edge after N.
- **Halt latency:** when `HLT` appears, `enable` drops combinationally in the same cycle, so the PC stays on the HLT address. HALTED is entered at the next rising edge. The HLT instruction is not counted.
- **STEP:** exactly one cycle with active strobes and one PC advance, then IDLE. A `step` held high re-triggers every second cycle (STEP, IDLE, STEP, …).

## Test plan
- **Reset:** assert `reset` for 2 cycles → all outputs 0, `instr_count`=0, `halted`=0. Holding `opcode`=LDI in IDLE keeps `enable`=0.
- **Run and halt:** `start` pulse with program LDI, ADDI, SUB, STO, HLT at PC 0–4 → per cycle:
  - `sel_a` = 01, 10, 10, 00.
  - `sel_b`/`op` match the decode list.
  - `wr_ram`=1 only on STO.
  - PC stops at 4, `halted`=1 one edge later, `instr_count`=4.
- **Single step:** in IDLE, one-cycle `step` with `opcode`=ADD → exactly one cycle with `rd_ram`=`wr_acc`=1, PC 0→1, return to IDLE, `instr_count`=1. `start`+`step` together → RUN.
- **Wrap:** `program_count`=2047, `opcode`=NOP 01000 in RUN → `new_program_count`=0, `enable`=1, all other strobes 0.
- **Reset mid-run and while halted:** assert `reset` in RUN after 3 instructions → IDLE, count 0. In HALTED, `start` is ignored; `reset` returns to IDLE.
- **Saturation:** COUNT_WIDTH=4, run 20 NOPs → `instr_count` holds at 15.
